// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and LSU result inputs and the register file write port.
// Latency: not applicable (signal bundle only).
// Backpressure: alu_stall holds the ALU result; lsu_ready gates LSU pushes.
interface wb_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
);
    logic                          alu_valid;
    logic [AW-1:0]                 alu_rd;
    logic [XLEN-1:0]               alu_data;
    logic                          alu_stall;
    logic                          lsu_valid;
    logic                          lsu_ready;
    logic [AW-1:0]                 lsu_rd;
    logic [XLEN-1:0]               lsu_data;
    logic                          RegWrite;
    logic [AW-1:0]                 addD;
    logic [XLEN-1:0]               WB_out;
    logic [2**AW-1:0]              busy_mask;
    logic [$clog2(DEPTH+1)-1:0]    fifo_count;

    // Pipeline side: produces results, observes the write port and backpressure.
    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_stall, lsu_ready, RegWrite, addD, WB_out, busy_mask, fifo_count
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_stall, lsu_ready, RegWrite, addD, WB_out, busy_mask, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results (priority) and FIFO-buffered LSU results into one registered write.
// Latency: ALU result written 1 cycle after presentation; LSU result at least 2 cycles after push.
// Backpressure: lsu_ready drops when the FIFO is full; alu_stall asserts when the FIFO head has aged out.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   wb
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [GW-1:0] STARVE_C = GW'(STARVE_MAX);
    localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

    // FIFO storage; per-slot valid bits drive busy_mask directly.
    logic [AW-1:0]   rd_mem_q  [DEPTH];
    logic [XLEN-1:0] dat_mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [GW-1:0]   age_q, age_d;

    // Registered write port.
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            nonempty;
    logic            ready;
    logic            stall;
    logic            push;
    logic            pop;
    logic [2**AW-1:0] busy;

    // Handshake decisions; ready and stall depend on registered state only.
    always_comb begin
        nonempty = (count_q != '0);
        ready    = !rst && (count_q < DEPTH_C);
        stall    = !rst && nonempty && (age_q >= STARVE_C);
        push     = wb.lsu_valid && ready;
        pop      = stall || (!wb.alu_valid && nonempty);
    end

    // Next-state: pick the write source, advance pointers, occupancy and head age.
    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        age_d    = age_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;

        if (pop) begin
            we_d            = (rd_mem_q[rd_ptr_q] != '0);
            addr_d          = rd_mem_q[rd_ptr_q];
            data_d          = dat_mem_q[rd_ptr_q];
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
        end else if (wb.alu_valid) begin
            we_d   = (wb.alu_rd != '0);
            addr_d = wb.alu_rd;
            data_d = wb.alu_data;
        end

        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // The head's age restarts whenever it leaves or there is no head at all.
        if (pop || !nonempty) begin
            age_d = '0;
        end else if (age_q < STARVE_C) begin
            age_d = age_q + GW'(1);
        end
    end

    // Control and write-port state with synchronous reset; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // FIFO payload: no reset needed, validity lives in vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]  <= wb.lsu_rd;
            dat_mem_q[wr_ptr_q] <= wb.lsu_data;
        end
    end

    // Registers still owed an LSU write; x0 is never a hazard.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                busy[rd_mem_q[i]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    assign wb.alu_stall  = stall;
    assign wb.lsu_ready  = ready;
    assign wb.RegWrite   = we_q;
    assign wb.addD       = addr_q;
    assign wb.WB_out     = data_q;
    assign wb.busy_mask  = busy;
    assign wb.fifo_count = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based model of the writeback rules.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int SM    = 4;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] d;
    } ent_t;

    logic clk;
    logic rst;

    wb_arbiter_if #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) bus ();

    wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    ent_t            q[$];
    int              age;
    bit              m_we;
    logic [AW-1:0]   m_addr;
    logic [XLEN-1:0] m_data;
    bit              held;
    ent_t            held_e;

    int n_chk  = 0;
    int n_pass = 0;
    bit t6_watch = 0;
    bit t6_seen  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare();
        logic [31:0] eb;
        eb = '0;
        foreach (q[i]) eb[q[i].rd] = 1'b1;
        eb[0] = 1'b0;
        chk("lsu_ready",  64'(bus.lsu_ready),  64'(!rst && q.size() < DEPTH));
        chk("alu_stall",  64'(bus.alu_stall),  64'(!rst && q.size() != 0 && age >= SM));
        chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        chk("busy_mask",  64'(bus.busy_mask),  64'(eb));
        chk("RegWrite",   64'(bus.RegWrite),   64'(m_we));
        chk("addD",       64'(bus.addD),       64'(m_addr));
        chk("WB_out",     64'(bus.WB_out),     64'(m_data));
        if (t6_watch && bus.RegWrite && (bus.addD == 5'd9 || bus.addD == 5'd10)) t6_seen = 1;
    endtask

    // Drive one cycle from a negedge, advance the model, then compare at the next negedge.
    // A result refused by alu_stall is re-presented unchanged, as the ALU would.
    task automatic cycle(input bit r, input bit av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                         input bit lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld);
        bit   stall_now, pop, ready_now;
        ent_t e;
        if (held && !r) begin
            av  = 1'b1;
            ard = held_e.rd;
            ad  = held_e.d;
        end
        rst           = r;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;

        if (r) begin
            q.delete();
            age    = 0;
            m_we   = 0;
            m_addr = '0;
            m_data = '0;
            held   = 0;
        end else begin
            stall_now = (q.size() != 0) && (age >= SM);
            ready_now = q.size() < DEPTH;
            pop       = stall_now || (!av && q.size() != 0);
            held      = av && stall_now;
            held_e    = '{ard, ad};
            if (pop) begin
                e      = q.pop_front();
                m_we   = (e.rd != 0);
                m_addr = e.rd;
                m_data = e.d;
                age    = 0;
            end else begin
                if (q.size() == 0) age = 0;
                else if (age < SM) age++;
                if (av) begin
                    m_we   = (ard != 0);
                    m_addr = ard;
                    m_data = ad;
                end else begin
                    m_we = 0;
                end
            end
            if (lv && ready_now) q.push_back('{lrd, ld});
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        cycle(0, 0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        logic [31:0] bm;
        held = 0;
        age  = 0;
        rst  = 1'b1;
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;

        // T1: reset with both sources requesting
        cycle(1, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
        cycle(1, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
        chk("t1_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("t1_ready",    64'(bus.lsu_ready), 64'd0);
        chk("t1_count",    64'(bus.fifo_count), 64'd0);
        rst = 1'b0; bus.alu_valid = 0; bus.lsu_valid = 0;
        #1;
        chk("t1_ready_after", 64'(bus.lsu_ready), 64'd1);

        // T2: ALU write, one cycle latency
        cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        chk("t2_we",   64'(bus.RegWrite), 64'd1);
        chk("t2_addr", 64'(bus.addD), 64'd5);
        chk("t2_data", 64'(bus.WB_out), 64'hDEADBEEF);
        idle();
        chk("t2_we_off", 64'(bus.RegWrite), 64'd0);

        // T3: write to x0 is suppressed
        cycle(0, 1, 5'd0, 32'h1, 0, '0, '0);
        chk("t3_we",    64'(bus.RegWrite), 64'd0);
        chk("t3_stall", 64'(bus.alu_stall), 64'd0);
        chk("t3_busy",  64'(bus.busy_mask), 64'd0);
        chk("t3_data",  64'(bus.WB_out), 64'h1);

        // T4: LSU write, two cycle latency with busy bit
        cycle(0, 0, '0, '0, 1, 5'd7, 32'h1234);
        chk("t4_busy_set", 64'(bus.busy_mask[7]), 64'd1);
        chk("t4_we_n1",    64'(bus.RegWrite), 64'd0);
        idle();
        chk("t4_we",       64'(bus.RegWrite), 64'd1);
        chk("t4_addr",     64'(bus.addD), 64'd7);
        chk("t4_data",     64'(bus.WB_out), 64'h1234);
        chk("t4_busy_clr", 64'(bus.busy_mask[7]), 64'd0);

        // T5: starvation guard with continuous ALU traffic
        cycle(0, 1, 5'd11, 32'hA0, 1, 5'd3, 32'h33);
        cycle(0, 1, 5'd12, 32'hA1, 1, 5'd4, 32'h44);
        chk("t5_ready_full", 64'(bus.lsu_ready), 64'd0);
        chk("t5_count",      64'(bus.fifo_count), 64'd2);
        cycle(0, 1, 5'd13, 32'hA2, 0, '0, '0);
        cycle(0, 1, 5'd14, 32'hA3, 0, '0, '0);
        chk("t5_no_stall_yet", 64'(bus.alu_stall), 64'd0);
        cycle(0, 1, 5'd15, 32'hA4, 0, '0, '0);
        chk("t5_stall", 64'(bus.alu_stall), 64'd1);
        cycle(0, 1, 5'd16, 32'hA6, 0, '0, '0);
        chk("t5_lsu3_we",   64'(bus.RegWrite), 64'd1);
        chk("t5_lsu3_addr", 64'(bus.addD), 64'd3);
        chk("t5_lsu3_data", 64'(bus.WB_out), 64'h33);
        chk("t5_unstall",   64'(bus.alu_stall), 64'd0);
        cycle(0, 1, 5'd17, 32'hA7, 0, '0, '0);
        chk("t5_held_addr", 64'(bus.addD), 64'd16);
        chk("t5_held_data", 64'(bus.WB_out), 64'hA6);
        idle();
        chk("t5_lsu4_addr", 64'(bus.addD), 64'd4);
        chk("t5_lsu4_data", 64'(bus.WB_out), 64'h44);
        chk("t5_empty",     64'(bus.fifo_count), 64'd0);

        // T6: reset while FIFO full loses both entries
        cycle(0, 1, 5'd20, 32'hB0, 1, 5'd9, 32'h99);
        cycle(0, 1, 5'd21, 32'hB1, 1, 5'd10, 32'h1010);
        bm = 32'h0000_0600;
        chk("t6_full",      64'(bus.fifo_count), 64'd2);
        chk("t6_busy_full", 64'(bus.busy_mask), 64'(bm));
        t6_watch = 1;
        cycle(1, 0, '0, '0, 0, '0, '0);
        chk("t6_count", 64'(bus.fifo_count), 64'd0);
        chk("t6_busy",  64'(bus.busy_mask), 64'd0);
        for (int i = 0; i < 10; i++) idle();
        chk("t6_never_written", 64'(t6_seen), 64'd0);
        t6_watch = 0;

        // Randomized traffic in phases of varying ALU/LSU density
        for (int i = 0; i < 4000; i++) begin
            int ap, lp;
            ap = (i / 500) % 4;
            lp = ((i / 250) % 3) + 1;
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) < ap,
                  AW'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 3) < lp,
                  AW'($urandom_range(0, 31)), $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
